pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage pipelined MIPS core. It decides every cycle whether the PC and IF/ID register advance, whether ID/EX receives a bubble, and whether IF/ID is flushed. It resolves load-use hazards (one-cycle stall) and taken branches/jumps resolved in ID (one-cycle flush). A debug halt/single-step FSM drains and freezes the pipeline. Sits between the ID-stage decode/compare logic and the PC, IF/ID and ID/EX register enables; also exports saturating stall/flush event counters.

---
 rtl/pipeline_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, ID-stage redirect flushes,
// debug halt/single-step drain FSM and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 16,
   parameter int DRAIN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             id_branch_taken,
   input  logic             id_jump,
   input  logic             dbg_halt_req,
   input  logic             dbg_step,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   typedef enum logic [1:0] {RUN, HALTING, HALTED, STEP} state_t;

   state_t          r_state, w_state_nxt;
   logic [DW-1:0]   r_drain, w_drain_nxt;
   logic            r_halted;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic            w_hazard, w_redirect;
   logic            w_stall_evt, w_flush_evt;

   assign w_hazard   = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   assign w_redirect = id_branch_taken || id_jump;

   // Default action is FREEZE; issuing states override it below.
   always_comb begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      w_stall_evt = 1'b0;
      w_flush_evt = 1'b0;
      w_state_nxt = r_state;
      w_drain_nxt = r_drain;
      if (!rst_n) begin
         ifid_flush  = 1'b1;
         w_state_nxt = RUN;
      end else begin
         case (r_state)
            RUN, STEP: begin
               if (r_state == RUN && dbg_halt_req) begin
                  w_state_nxt = HALTING;
                  w_drain_nxt = DW'(DRAIN - 1);
               end else begin
                  if (w_hazard) begin
                     w_stall_evt = 1'b1;
                  end else if (w_redirect) begin
                     pc_we       = 1'b1;
                     ifid_we     = 1'b1;
                     ifid_flush  = 1'b1;
                     idex_bubble = 1'b0;
                     w_flush_evt = 1'b1;
                  end else begin
                     pc_we       = 1'b1;
                     ifid_we     = 1'b1;
                     idex_bubble = 1'b0;
                  end
                  if (r_state == STEP) begin
                     w_state_nxt = HALTING;
                     w_drain_nxt = DW'(DRAIN - 1);
                  end
               end
            end
            HALTING: begin
               if (r_drain == '0) w_state_nxt = HALTED;
               else               w_drain_nxt = r_drain - 1'b1;
            end
            HALTED: begin
               if (!dbg_halt_req) w_state_nxt = RUN;
               else if (dbg_step) w_state_nxt = STEP;
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_drain     <= '0;
         r_halted    <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_drain  <= w_drain_nxt;
         r_halted <= (w_state_nxt == HALTED);
         if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign halted      = r_halted;
   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=2 to reach saturation, DRAIN=3).
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, id_branch_taken, id_jump;
   logic       dbg_halt_req, dbg_step;
   logic       pc_we, ifid_we, ifid_flush, idex_bubble, halted;
   logic [1:0] stall_count, flush_count;
   logic [3:0] act;

   int n_checks = 0;
   int n_pass   = 0;

   // {pc_we, ifid_we, ifid_flush, idex_bubble}
   localparam logic [3:0] A_STALL = 4'b0001;
   localparam logic [3:0] A_FRZ   = 4'b0001;
   localparam logic [3:0] A_FLUSH = 4'b1110;
   localparam logic [3:0] A_ADV   = 4'b1100;
   localparam logic [3:0] A_RST   = 4'b0011;

   assign act = {pc_we, ifid_we, ifid_flush, idex_bubble};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(2), .DRAIN(3)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .id_branch_taken(id_branch_taken), .id_jump(id_jump),
      .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .halted(halted),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   task automatic idle_inputs();
      id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
      id_uses_rt = 1'b0; ex_mem_read = 1'b0;
      id_branch_taken = 1'b0; id_jump = 1'b0;
      dbg_halt_req = 1'b0; dbg_step = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (act !== A_RST) $display("FAIL reset_act got %b want %b", act, A_RST); else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({halted, stall_count, flush_count} !== 5'b0)
         $display("FAIL reset_regs got h=%b s=%0d f=%0d want 0/0/0", halted, stall_count, flush_count);
      else n_pass++;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (act !== A_ADV) $display("FAIL reset_release_act got %b want %b", act, A_ADV); else n_pass++;
   endtask

   task automatic test_load_use();
      apply_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
      #1;
      n_checks++;
      if (act !== A_STALL) $display("FAIL loaduse_stall got %b want %b", act, A_STALL); else n_pass++;
      @(negedge clk);
      ex_mem_read = 1'b0;
      #1;
      n_checks++;
      if (act !== A_ADV) $display("FAIL loaduse_adv got %b want %b", act, A_ADV); else n_pass++;
      n_checks++;
      if (stall_count !== 2'd1) $display("FAIL loaduse_cnt got %0d want 1", stall_count); else n_pass++;
   endtask

   task automatic test_zero_rt_filter();
      apply_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #1;
      n_checks++;
      if (act !== A_ADV) $display("FAIL zero_reg got %b want %b", act, A_ADV); else n_pass++;
      ex_rt = 5'd10; id_rt = 5'd10; id_rs = 5'd1; id_uses_rt = 1'b0;
      #1;
      n_checks++;
      if (act !== A_ADV) $display("FAIL rt_unused got %b want %b", act, A_ADV); else n_pass++;
      id_uses_rt = 1'b1;
      #1;
      n_checks++;
      if (act !== A_STALL) $display("FAIL rt_used got %b want %b", act, A_STALL); else n_pass++;
   endtask

   task automatic test_branch_dep();
      apply_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_branch_taken = 1'b1;
      #1;
      n_checks++;
      if (act !== A_STALL) $display("FAIL br_dep_stall got %b want %b", act, A_STALL); else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({stall_count, flush_count} !== 4'b0100)
         $display("FAIL br_dep_cnt1 got s=%0d f=%0d want s=1 f=0", stall_count, flush_count);
      else n_pass++;
      ex_mem_read = 1'b0;
      #1;
      n_checks++;
      if (act !== A_FLUSH) $display("FAIL br_flush got %b want %b", act, A_FLUSH); else n_pass++;
      @(negedge clk);
      id_branch_taken = 1'b0; id_jump = 1'b1;
      #1;
      n_checks++;
      if (flush_count !== 2'd1) $display("FAIL br_flush_cnt got %0d want 1", flush_count); else n_pass++;
      n_checks++;
      if (act !== A_FLUSH) $display("FAIL jump_flush got %b want %b", act, A_FLUSH); else n_pass++;
      @(negedge clk);
      id_jump = 1'b0;
      n_checks++;
      if (flush_count !== 2'd2) $display("FAIL jump_cnt got %0d want 2", flush_count); else n_pass++;
   endtask

   task automatic test_halt();
      apply_reset();
      dbg_halt_req = 1'b1; id_branch_taken = 1'b1;
      ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
      #1;
      n_checks++;
      if (act !== A_FRZ) $display("FAIL halt_prio got %b want %b", act, A_FRZ); else n_pass++;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({halted, act} !== {1'b0, A_FRZ})
            $display("FAIL halt_drain%0d got h=%b act=%b want h=0 act=%b", i, halted, act, A_FRZ);
         else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (halted !== 1'b1) $display("FAIL halt_reached got %b want 1", halted); else n_pass++;
      n_checks++;
      if ({stall_count, flush_count} !== 4'b0)
         $display("FAIL halt_no_events got s=%0d f=%0d want 0/0", stall_count, flush_count);
      else n_pass++;
      idle_inputs();
      #1;
      n_checks++;
      if (act !== A_FRZ) $display("FAIL halted_frz got %b want %b", act, A_FRZ); else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({halted, act} !== {1'b0, A_ADV})
         $display("FAIL resume got h=%b act=%b want h=0 act=%b", halted, act, A_ADV);
      else n_pass++;
   endtask

   task automatic test_halt_drain_completes();
      apply_reset();
      dbg_halt_req = 1'b1;
      @(negedge clk);
      dbg_halt_req = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (halted !== 1'b1) $display("FAIL drain_complete got %b want 1", halted); else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({halted, act} !== {1'b0, A_ADV})
         $display("FAIL drain_resume got h=%b act=%b want h=0 act=%b", halted, act, A_ADV);
      else n_pass++;
   endtask

   task automatic test_step();
      apply_reset();
      dbg_halt_req = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (halted !== 1'b1) $display("FAIL step_pre_halt got %b want 1", halted); else n_pass++;
      dbg_step = 1'b1;
      @(negedge clk);
      dbg_step = 1'b0;
      #1;
      n_checks++;
      if ({halted, act} !== {1'b0, A_ADV})
         $display("FAIL step_issue got h=%b act=%b want h=0 act=%b", halted, act, A_ADV);
      else n_pass++;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         dbg_step = (i == 2);
         #1;
         n_checks++;
         if ({halted, act} !== {1'b0, A_FRZ})
            $display("FAIL step_drain%0d got h=%b act=%b want h=0 act=%b", i, halted, act, A_FRZ);
         else n_pass++;
      end
      @(negedge clk);
      dbg_step = 1'b0;
      n_checks++;
      if (halted !== 1'b1) $display("FAIL step_rehalt got %b want 1", halted); else n_pass++;
   endtask

   task automatic test_back_to_back_saturation();
      apply_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (stall_count !== 2'd2) $display("FAIL back_to_back got %0d want 2", stall_count); else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (stall_count !== 2'd3) $display("FAIL stall_sat got %0d want 3", stall_count); else n_pass++;
      ex_mem_read = 1'b0;
   endtask

   task automatic test_reset_mid_halt();
      apply_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd6; id_rs = 5'd6;
      @(negedge clk);
      ex_mem_read = 1'b0; id_jump = 1'b1;
      @(negedge clk);
      id_jump = 1'b0; dbg_halt_req = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (act !== A_RST) $display("FAIL midrst_act got %b want %b", act, A_RST); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1; dbg_halt_req = 1'b0;
      #1;
      n_checks++;
      if ({halted, stall_count, flush_count} !== 5'b0)
         $display("FAIL midrst_regs got h=%b s=%0d f=%0d want 0/0/0", halted, stall_count, flush_count);
      else n_pass++;
      n_checks++;
      if (act !== A_ADV) $display("FAIL midrst_run got %b want %b", act, A_ADV); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_load_use();
      test_zero_rt_filter();
      test_branch_dep();
      test_halt();
      test_halt_drain_completes();
      test_step();
      test_back_to_back_saturation();
      test_reset_mid_halt();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
